// File: rtl/sdp_brdma_unpack_if.sv
// Beat-in / chunk-out stream bundle between the BRDMA egress port and the BS datapath.
// Latency: none, wires only.
// Backpressure: in_pvld/in_prdy on the beat side, out_pvld/out_prdy on the chunk side.
interface sdp_brdma_unpack_if #(
  parameter int IN_DW  = 256,
  parameter int OUT_DW = 64,
  parameter int RATIO  = IN_DW / OUT_DW
);
  logic                    in_pvld;
  logic                    in_prdy;
  logic [IN_DW+RATIO-1:0]  in_pd;
  logic                    out_pvld;
  logic                    out_prdy;
  logic [OUT_DW-1:0]       out_pd;
  logic                    out_last;

  // Upstream DMA port plus downstream datapath, seen from outside the unpacker.
  modport master (
    output in_pvld, in_pd, out_prdy,
    input  in_prdy, out_pvld, out_pd, out_last
  );

  // The unpacker itself.
  modport slave (
    input  in_pvld, in_pd, out_prdy,
    output in_prdy, out_pvld, out_pd, out_last
  );
endinterface

// File: rtl/sdp_brdma_unpack.sv
// Serialises masked wide DMA beats into narrow chunks, counts chunks per layer, flags the last one.
// Latency: beat accepted at edge N shows its first chunk from cycle N+1; one chunk per cycle.
// Backpressure: chunk held stable while out_prdy=0; in_prdy only when the held beat is (about to be) drained.
// Optional stall counter port dp2reg_unpack_stall is built when SDP_BRDMA_UNPACK_PERF_EN is defined.
module sdp_brdma_unpack #(
  parameter int IN_DW  = 256,
  parameter int OUT_DW = 64,
  parameter int RATIO  = IN_DW / OUT_DW
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 op_load,
  input  logic [31:0]          cfg_chunk_total,
  sdp_brdma_unpack_if.slave    dma,
  output logic                 done,
  output logic                 err_overrun
`ifdef SDP_BRDMA_UNPACK_PERF_EN
  ,
  output logic [31:0]          dp2reg_unpack_stall
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // Holding register: one beat plus the chunks of it not yet sent.
  logic [IN_DW-1:0]    buf_dat;
  logic [RATIO-1:0]    rem_mask;
  logic [31:0]         cnt;
  logic [31:0]         total;

  logic [RATIO-1:0]    in_mask;
  logic [IN_DW-1:0]    in_dat;
  logic [RATIO-1:0]    sel_bit;
  logic [RATIO-1:0]    rem_after;
  logic [OUT_DW-1:0]   chunk;
  logic                pvld;
  logic                prdy_in;
  logic                last;
  logic                xfer;
  logic                in_acc;

  assign in_mask = dma.in_pd[IN_DW +: RATIO];
  assign in_dat  = dma.in_pd[IN_DW-1:0];

  // Select the lowest-index chunk still pending in the held beat.
  always_comb begin
    sel_bit = '0;
    chunk   = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (rem_mask[i]) begin
        sel_bit    = '0;
        sel_bit[i] = 1'b1;
        chunk      = buf_dat[i*OUT_DW +: OUT_DW];
      end
    end
  end

  assign rem_after = rem_mask & ~sel_bit;

  // Next-state and handshake decode; a beat may enter in the same cycle the last held chunk leaves.
  always_comb begin
    state_nxt = state;
    pvld      = 1'b0;
    prdy_in   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (op_load) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        pvld    = |rem_mask;
        last    = pvld && (cnt == total);
        prdy_in = (rem_after == '0) && (!pvld || dma.out_prdy);
        if (pvld && dma.out_prdy && last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer         = pvld & dma.out_prdy;
  assign in_acc       = dma.in_pvld & prdy_in;
  assign dma.in_prdy  = prdy_in;
  assign dma.out_pvld = pvld;
  assign dma.out_last = last;
  // Zero the bus when nothing is offered so reset and idle present a clean 0.
  assign dma.out_pd   = pvld ? chunk : '0;

  // State register.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holding buffer, chunk counter, layer end bookkeeping and the done pulse.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      buf_dat     <= '0;
      rem_mask    <= '0;
      cnt         <= '0;
      total       <= '0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      done <= xfer & last;
      if (state == IDLE) begin
        if (op_load) begin
          total       <= cfg_chunk_total;
          cnt         <= '0;
          rem_mask    <= '0;
          err_overrun <= 1'b0;
        end
      end else begin
        if (xfer) begin
          cnt <= cnt + 32'd1;
        end
        if (xfer && last) begin
          // Anything still pending, or arriving alongside the final chunk, is past the layer end.
          rem_mask <= '0;
          if ((|rem_after) || (in_acc && (|in_mask))) begin
            err_overrun <= 1'b1;
          end
        end else if (in_acc) begin
          // An all-zero mask simply leaves the buffer empty: the beat is dropped.
          rem_mask <= in_mask;
          buf_dat  <= in_dat;
        end else if (xfer) begin
          rem_mask <= rem_after;
        end
      end
    end
  end

`ifdef SDP_BRDMA_UNPACK_PERF_EN
  logic [31:0] stall_cnt;

  // Saturating count of RUN cycles where a chunk is offered but not taken.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && op_load) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && pvld && !dma.out_prdy && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign dp2reg_unpack_stall = stall_cnt;
`endif

endmodule

// File: doc/sdp_brdma_unpack.md
Name: sdp_brdma_unpack

Overview:
- Sits directly downstream of the SDP BRDMA egress port (alu or mul stream).
- Takes wide DMA-sized operand beats, each with a per-chunk valid mask, and serialises them into narrow chunks at one chunk per cycle for the BS ALU/MUL datapath.
- Counts chunks per layer, flags the final chunk, and pulses done.

Parameters:
- IN_DW, 256, data width of one input beat in bits.
- OUT_DW, 64, data width of one output chunk; IN_DW must be an integer multiple of OUT_DW.
- RATIO, IN_DW/OUT_DW (4), chunks per beat and the mask width.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset, synchronous, active-low.
- op_load  in  1  layer start pulse.
- cfg_chunk_total  in  32  number of output chunks in the layer minus 1; sampled on op_load.
- in_pvld  in  1  input beat valid.
- in_prdy  out  1  input beat ready.
- in_pd  in  IN_DW+RATIO  {mask[RATIO-1:0], data[IN_DW-1:0]}; mask bit i qualifies data[i*OUT_DW +: OUT_DW].
- out_pvld  out  1  chunk valid.
- out_prdy  in  1  chunk ready.
- out_pd  out  OUT_DW  chunk data.
- out_last  out  1  high with the final chunk of the layer.
- done  out  1  one-cycle pulse after the final chunk is accepted.
- err_overrun  out  1  sticky flag: valid chunks were discarded after the final chunk; cleared on op_load.

Behaviour:
- Reset (synchronous, rstn=0 at a clock edge): state=IDLE, holding buffer empty, chunk counter=0. All outputs 0: in_prdy, out_pvld, out_pd, out_last, done, err_overrun.
- State IDLE:
  - in_prdy=0, out_pvld=0.
  - op_load moves to RUN, latches cfg_chunk_total, clears the counter and err_overrun.
- State RUN:
  - Holding register keeps one beat plus a remaining-mask.
  - out_pd is the lowest-index chunk still set in the remaining-mask; out_pvld=1 whenever the remaining-mask is nonzero.
- Handshake:
  - An output transfer is out_pvld&out_prdy. It clears that mask bit and increments the counter.
  - in_prdy = RUN & (remaining-mask==0 | (exactly one bit left & out_prdy)). This allows back-to-back beats with no bubble.
  - in_prdy is combinational from out_prdy. out_pd and out_pvld are registered.
- Latency: beat accepted at edge N puts its first chunk on out_pd from cycle N+1.
- Throughput: one chunk per cycle when out_prdy is held high.
- Mask all-zero beat: accepted and dropped; no output produced; the counter is unchanged.
- Held data must stay stable while out_pvld=1 and out_prdy=0.
- Layer end:
  - out_last=1 while out_pvld and counter==latched total.
  - On that transfer: discard any remaining mask bits, setting err_overrun if any were set.
  - Go to IDLE; done=1 on the following cycle only.
- Counter is 32 bits; it cannot wrap because the layer ends at the total.
- cfg_chunk_total=0 means a single-chunk layer.
- op_load while in RUN is ignored.
- Reset asserted mid-layer: buffer, counter and state are cleared; no done is issued.

Optional Feature:
- Macro: SDP_BRDMA_UNPACK_PERF_EN.
- When defined:
  - Adds output port dp2reg_unpack_stall, 32 bits.
  - It counts cycles in RUN with out_pvld=1 & out_prdy=0.
  - It clears on op_load and saturates at 0xFFFFFFFF.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Full-mask streaming: op_load with total=7; two beats, mask 4'hF, data chunks A0..A3 and B0..B3; out_prdy=1.
  - Required: out_pd A0,A1,A2,A3,B0..B3 on 8 consecutive cycles starting the cycle after the first accept.
  - Required: out_last only on B3; done one cycle after B3; in_prdy high during A3.
- Sparse masks: total=2; beat mask 4'b1010 (chunks C1, C3), then a beat with mask 4'b0000, then mask 4'b0001 (D0).
  - Required: output C1, C3, D0; the zero-mask beat is consumed without output.
- Backpressure: out_prdy toggles 1,0,0,1 during a full-mask beat.
  - Required: out_pd held constant while stalled; no chunk lost or duplicated.
  - With SDP_BRDMA_UNPACK_PERF_EN: dp2reg_unpack_stall=2.
- Overrun: total=1; beat mask 4'hF.
  - Required: two chunks out, out_last on the second; err_overrun=1 after it; in_prdy=0 in IDLE.
- Mid-layer reset: nvdla_core_rstn=0 for one edge after 3 of 8 chunks.
  - Required: all outputs 0 next cycle; no done.
  - Required: a new op_load with total=0 produces exactly one chunk with out_last, then done.
